mult_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one 16x8 -> 24-bit `mult` unit between N_REQ requesters.

---
 rtl/mult_pkg.sv | 8 +
 rtl/mult_arbiter_rr.sv | 23 ++
 rtl/mult_arbiter.sv | 95 +++++++++
 tb/tb_mult_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: FSM state encoding and default widths shared by the multiplier arbiter.
package mult_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, DONE = 2'b11} state_e;
    localparam int N_REQ_DEF = 4;
    localparam int A_W_DEF = 16;
    localparam int B_W_DEF = 8;
    localparam int Y_W_DEF = 24;
endpackage

// File: rtl/mult_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);
    logic [IW:0] s;
    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx_o = '0;
        s = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr_i} + (IW + 1)'(k);
            if (s >= (IW + 1)'(N_REQ)) s = s - (IW + 1)'(N_REQ);
            if (req_i[s[IW-1:0]]) idx_o = s[IW-1:0];
        end
    end
    assign gnt_o = (|req_i) ? N_REQ'(1) << idx_o : '0;
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sequencer sharing one external multiplier between N_REQ requesters.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int Y_W = Y_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*A_W-1:0] a_bi,
    input  logic [N_REQ*B_W-1:0] b_bi,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [Y_W-1:0]     y_bo,
    output logic [1:0]         busy_o,
    output logic [A_W-1:0]     m_a_bo,
    output logic [B_W-1:0]     m_b_bo,
    output logic               m_start_o,
    input  logic               m_busy_i,
    input  logic [Y_W-1:0]     m_y_bi
);
    localparam int IW = $clog2(N_REQ);
    state_e           state_q;
    logic [N_REQ-1:0] gnt_q, done_q, arb_gnt;
    logic [IW-1:0]    ptr_q, idx_q, arb_idx;
    logic [Y_W-1:0]   y_q;
    logic [A_W-1:0]   m_a_q;
    logic [B_W-1:0]   m_b_q;
    logic             m_start_q, cnt_q;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req_i(req_i),
        .ptr_i(ptr_q),
        .gnt_o(arb_gnt),
        .idx_o(arb_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q <= '0;
            done_q <= '0;
            ptr_q <= '0;
            idx_q <= '0;
            y_q <= '0;
            m_a_q <= '0;
            m_b_q <= '0;
            m_start_q <= 1'b0;
            cnt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|req_i) begin
                    gnt_q <= arb_gnt;
                    idx_q <= arb_idx;
                    m_a_q <= a_bi[arb_idx*A_W +: A_W];
                    m_b_q <= b_bi[arb_idx*B_W +: B_W];
                    m_start_q <= 1'b1;
                    cnt_q <= 1'b0;
                    state_q <= ISSUE;
                end
                // Start stays high for two cycles so the multiplier is sure to sample it.
                ISSUE: begin
                    cnt_q <= 1'b1;
                    if (cnt_q) begin
                        m_start_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: if (!m_busy_i && !m_start_q) begin
                    y_q <= m_y_bi;
                    done_q <= gnt_q;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q <= '0;
                    gnt_q <= '0;
                    ptr_q <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o = gnt_q;
    assign done_o = done_q;
    assign y_bo = y_q;
    assign busy_o = state_q;
    assign m_a_bo = m_a_q;
    assign m_b_bo = m_b_q;
    assign m_start_o = m_start_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed tests of mult_arbiter driving a behavioural multiplier, checked by a transaction model.
module tb_mult_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] a_bi = '0;
    logic [31:0] b_bi = '0;
    logic [3:0]  gnt_o, done_o;
    logic [23:0] y_bo;
    logic [1:0]  busy_o;
    logic [15:0] m_a;
    logic [7:0]  m_b;
    logic        m_start;
    logic        mb;
    logic [1:0]  mc;
    logic [23:0] my;
    logic [15:0] ma;
    logic [7:0]  mbb;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mult_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .a_bi(a_bi), .b_bi(b_bi),
        .gnt_o(gnt_o), .done_o(done_o), .y_bo(y_bo), .busy_o(busy_o),
        .m_a_bo(m_a), .m_b_bo(m_b), .m_start_o(m_start),
        .m_busy_i(mb), .m_y_bi(my)
    );

    // Shared multiplier: busy for three cycles after sampling start, ignores start while busy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mb <= 1'b0; mc <= '0; my <= '0; ma <= '0; mbb <= '0;
        end else if (mb) begin
            if (mc == 0) begin
                mb <= 1'b0;
                my <= 24'(ma) * 24'(mbb);
            end else mc <= mc - 1'b1;
        end else if (m_start) begin
            mb <= 1'b1; mc <= 2'd2; ma <= m_a; mbb <= m_b;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: grant at t=0, ISSUE t=0..1, WAIT t=2..4, DONE t=5, idle t=6.
    initial begin
        bit active = 0;
        int t = 0, eptr = 0, eidx = 0;
        logic [23:0] ey, last_y = '0;
        logic [15:0] ea = '0;
        logic [7:0]  eb = '0;
        logic [3:0]  r, eg, edone;
        logic [63:0] ra;
        logic [31:0] rb;
        logic [1:0]  ebusy;
        forever begin
            @(posedge clk);
            r = req; ra = a_bi; rb = b_bi;
            #1;
            if (rst) begin
                active = 0; eptr = 0; last_y = '0;
            end else if (active) begin
                t++;
                if (t == 6) begin
                    active = 0;
                    eptr = (eidx + 1) % 4;
                end
            end else if (|r) begin
                for (int k = 3; k >= 0; k--)
                    if (r[(eptr + k) % 4]) eidx = (eptr + k) % 4;
                active = 1; t = 0;
                ea = ra[eidx*16 +: 16];
                eb = rb[eidx*8 +: 8];
                ey = 24'(ea) * 24'(eb);
            end
            eg = active ? 4'(1 << eidx) : 4'd0;
            ebusy = !active ? 2'd0 : (t < 2) ? 2'd1 : (t < 5) ? 2'd2 : 2'd3;
            edone = (active && t == 5) ? eg : 4'd0;
            if (active && t == 5) last_y = ey;
            chk("mdl gnt", gnt_o, eg);
            chk("mdl busy", busy_o, ebusy);
            chk("mdl done", done_o, edone);
            chk("mdl start", m_start, active && t < 2);
            chk("mdl y", y_bo, last_y);
            if (active && t < 2) begin
                chk("mdl m_a", m_a, ea);
                chk("mdl m_b", m_b, eb);
            end
        end
    end

    task automatic set_op(input int k, input logic [15:0] a, input logic [7:0] b);
        a_bi[k*16 +: 16] = a;
        b_bi[k*8 +: 8] = b;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic wait_done(input int k, input logic [23:0] ey, input string nm);
        int n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (done_o == 0 && n < 40);
        chk({nm, " done"}, done_o, 32'(1 << k));
        chk({nm, " y"}, y_bo, ey);
    endtask

    initial begin
        int n;
        #1;
        chk("rst gnt", gnt_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst y", y_bo, 0);
        chk("rst start", m_start, 0);
        chk("rst m_a", m_a, 0);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        // Single request
        @(negedge clk); set_op(0, 3, 5); req = 4'b0001;
        wait_done(0, 15, "t1");
        chk("t1 gnt", gnt_o, 1);
        @(negedge clk); req = '0;
        @(negedge clk); @(negedge clk);
        chk("t1 idle", busy_o, 0);
        // Simultaneous requests from pointer 0
        do_reset();
        set_op(0, 7, 9); set_op(2, 100, 2); req = 4'b0101;
        wait_done(0, 63, "t2a");
        @(negedge clk); req[0] = 1'b0;
        wait_done(2, 200, "t2b");
        @(negedge clk); req = '0;
        // All four held high: rotation 0,1,2,3,0,1
        do_reset();
        for (int k = 0; k < 4; k++) set_op(k, 16'(k + 1), 8'(10 * (k + 1)));
        req = 4'b1111;
        wait_done(0, 10, "t3 0");
        wait_done(1, 40, "t3 1");
        wait_done(2, 90, "t3 2");
        wait_done(3, 160, "t3 3");
        wait_done(0, 10, "t3 4");
        wait_done(1, 40, "t3 5");
        @(negedge clk); req = '0;
        // Boundary operands and result hold
        @(negedge clk); set_op(0, 0, 200); req = 4'b0001;
        wait_done(0, 0, "t4 zero");
        @(negedge clk); set_op(0, 16'hFFFF, 8'hFF);
        wait_done(0, 24'd16711425, "t4 max");
        @(negedge clk); req = '0;
        repeat (4) @(negedge clk);
        chk("t4 hold", y_bo, 24'd16711425);
        // Operand change after grant
        set_op(0, 10, 10); req = 4'b0001;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (gnt_o == 0 && n < 40);
        chk("t5 gnt", gnt_o, 1);
        @(negedge clk); set_op(0, 999, 99);
        wait_done(0, 100, "t5");
        @(negedge clk); req = '0;
        // Reset in WAIT
        @(negedge clk); set_op(0, 5, 5); req = 4'b0001;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (busy_o != 2'd2 && n < 40);
        chk("t6 in wait", busy_o, 2);
        rst = 1'b1;
        #1;
        chk("t6 gnt", gnt_o, 0);
        chk("t6 done", done_o, 0);
        chk("t6 busy", busy_o, 0);
        chk("t6 y", y_bo, 0);
        chk("t6 start", m_start, 0);
        chk("t6 m_a", m_a, 0);
        chk("t6 m_b", m_b, 0);
        repeat (3) begin
            @(posedge clk); #2;
            chk("t6 no done", done_o, 0);
        end
        @(negedge clk); req = '0; rst = 1'b0;
        @(negedge clk); set_op(0, 2, 3); req = 4'b0001;
        wait_done(0, 6, "t6 after");
        @(negedge clk); req = '0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
